// File: rtl/gumnut_data_arbiter.sv
// gumnut_data_arbiter
// Round-robin arbiter sharing the data-memory bus between the Gumnut core data
// port (m0) and a second master (m1, DMA/debug). A grant is locked for as long
// as the owner holds cyc. The owner's cyc/stb/we/adr/dat are muxed to the slave.
// ack and read data are routed back to the owner only.
//
// Optional feature (macro ARB_TIMEOUT_EN): a watchdog that aborts a strobe left
// unacknowledged for TO_CYCLES cen-qualified cycles. It pulses the owner's err
// and locks that master out until it drops cyc. Without the macro, err is
// tied low and the arbiter waits for ack indefinitely.
//
// Ports:
//   clk, rst (async, active low), cen (clock enable for all state)
//   m0_* / m1_*   master side: cyc, stb, we, adr, dat in; dat, ack, err out
//   s_*           slave side: cyc, stb, we, adr, dat out; dat, ack in
//   gnt_o         one-hot owner: 01=m0, 10=m1, 00=none
module gumnut_data_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned TO_CYCLES = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e state_q;
  logic   last_gnt_q;  // 0: m0 granted last, 1: m1 granted last
  logic   own0, own1;
  logic   req0, req1;
  logic   timeout;     // owner's strobe aborted on this cen edge
  logic   blank;       // suppress slave cyc/stb for the cycle after a timeout

  assign own0 = (state_q == StGnt0);
  assign own1 = (state_q == StGnt1);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES);

  logic [CntW-1:0] cnt_q;
  logic            err0_q, err1_q;
  logic            lock0_q, lock1_q;
  logic            own_stb;

  // A timed-out master may not request again until it has dropped cyc.
  assign req0     = m0_cyc_i & ~lock0_q;
  assign req1     = m1_cyc_i & ~lock1_q;
  assign own_stb  = (own0 & m0_cyc_i & m0_stb_i) | (own1 & m1_cyc_i & m1_stb_i);
  assign timeout  = own_stb & ~s_ack_i & (cnt_q == CntW'(TO_CYCLES - 1));
  assign blank    = err0_q | err1_q;
  assign m0_err_o = err0_q;
  assign m1_err_o = err1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      lock0_q <= 1'b0;
      lock1_q <= 1'b0;
    end else begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      if (cen) begin
        if (!m0_cyc_i) lock0_q <= 1'b0;
        if (!m1_cyc_i) lock1_q <= 1'b0;
        if (timeout) begin
          cnt_q  <= '0;
          err0_q <= own0;
          err1_q <= own1;
          if (own0) lock0_q <= 1'b1;
          if (own1) lock1_q <= 1'b1;
        end else if (own_stb && !s_ack_i) begin
          cnt_q <= cnt_q + 1'b1;
        end else begin
          // Idle, stb low, ack, or owner dropped cyc (grant change)
          cnt_q <= '0;
        end
      end
    end
  end
`else
  logic unused_to;

  assign req0      = m0_cyc_i;
  assign req1      = m1_cyc_i;
  assign timeout   = 1'b0;
  assign blank     = 1'b0;
  assign m0_err_o  = 1'b0;
  assign m1_err_o  = 1'b0;
  assign unused_to = ^TO_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
    end else if (cen) begin
      unique case (state_q)
        StIdle: begin
          if (req0 && (!req1 || last_gnt_q)) begin
            state_q    <= StGnt0;
            last_gnt_q <= 1'b0;
          end else if (req1) begin
            state_q    <= StGnt1;
            last_gnt_q <= 1'b1;
          end
        end
        StGnt0: begin
          if (timeout || !m0_cyc_i) begin
            if (req1) begin
              state_q    <= StGnt1;
              last_gnt_q <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StGnt1: begin
          if (timeout || !m1_cyc_i) begin
            if (req0) begin
              state_q    <= StGnt0;
              last_gnt_q <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    if (own0) begin
      s_cyc_o  = m0_cyc_i & ~blank;
      s_stb_o  = m0_stb_i & ~blank;
      s_we_o   = m0_we_i;
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      m0_ack_o = s_ack_i & m0_stb_i & ~blank;
      m0_dat_o = s_dat_i;
    end else if (own1) begin
      s_cyc_o  = m1_cyc_i & ~blank;
      s_stb_o  = m1_stb_i & ~blank;
      s_we_o   = m1_we_i;
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      m1_ack_o = s_ack_i & m1_stb_i & ~blank;
      m1_dat_o = s_dat_i;
    end
  end

  assign gnt_o = {own1, own0};

endmodule

// File: doc/gumnut_data_arbiter.md
Name: gumnut_data_arbiter

Overview:
Two-master arbiter sharing the single Wishbone-style data memory bus (cyc/stb/we/ack, 8-bit address, 8-bit data) between the Gumnut core data port (m0) and a second master (m1, DMA or debug port). It sits between the masters and data_mem. Grants are round-robin and locked for the whole cyc. The selected master's strobe, address, data and write-enable are muxed to the slave, and ack/read-data are routed back to that master only.

Parameters:
AW, 8, address width
DW, 8, data width
TO_CYCLES, 15, watchdog limit in cen-qualified cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cen  in  1  clock enable; state advances only on clk edges with cen=1
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 bus cycle, strobe, write-enable
m0_adr_i  in  AW  master 0 address
m0_dat_i  in  DW  master 0 write data
m0_dat_o  out  DW  master 0 read data
m0_ack_o  out  1  master 0 acknowledge
m0_err_o  out  1  master 0 timeout error
m1_*  same set and meaning for master 1
s_cyc_o, s_stb_o, s_we_o  out  1 each  to data_mem
s_adr_o  out  AW  to data_mem
s_dat_o  out  DW  write data to data_mem
s_dat_i  in  DW  read data from data_mem
s_ack_i  in  1  acknowledge from data_mem
gnt_o  out  2  one-hot owner: 01=m0, 10=m1, 00=none

Behaviour:
- States: IDLE, GNT0, GNT1. Register last_gnt holds the master granted most recently and resets to m1, so m0 wins the first tie.
- Reset (rst=0, asynchronous, valid at any time including mid-transfer): state IDLE, gnt_o=00, last_gnt=m1. All s_* outputs, mX_ack_o, mX_err_o and mX_dat_o are 0. Any in-flight transfer is dropped with no ack.
- IDLE: s_cyc/stb/we=0, s_adr/s_dat=0. On a cen edge, the arbiter grants whichever master has cyc=1. If both have cyc=1, it grants the one not equal to last_gnt. Grant latency is 1 cycle from cyc assertion.
- GNTx: s_cyc_o=mx_cyc_i, s_stb_o=mx_stb_i, s_we_o=mx_we_i, s_adr_o=mx_adr_i, s_dat_o=mx_dat_i (combinational). mx_ack_o=s_ack_i & mx_stb_i. mx_dat_o=s_dat_i. The other master sees ack=0 and dat_o=0.
- Lock: the owner keeps the grant for as long as its cyc=1, across any number of stb/ack beats. There is no pre-emption.
- Release: on a cen edge with the owner's cyc=0, the arbiter moves directly to GNT(other) if the other master's cyc=1 (no dead cycle). Otherwise it moves to IDLE. last_gnt is updated on every grant.
- Owner drops cyc in the same cycle as s_ack_i: the ack is delivered, then the release rule applies.
- s_ack_i while no stb is active, or in IDLE, is ignored.
- cen=0: state, last_gnt and counter are frozen. The combinational muxing of the current owner continues.
- Owner never asserting stb: the grant is held until it drops cyc.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A counter increments on cen edges while the owner has stb=1 and s_ack_i=0. It clears on ack, on grant change, or when stb=0.
  - When the counter reaches TO_CYCLES, the owner's err_o pulses high for 1 cycle and s_cyc_o/s_stb_o are forced to 0 for that cycle.
  - On the same edge the state moves to GNT(other) if the other master requests, otherwise to IDLE.
  - The timed-out master is locked out until it deasserts cyc.
- Undefined: no counter is built, mX_err_o are tied to 0, and the arbiter waits indefinitely for ack.

Test Plan:
1. Drive rst=0 during an active m0 write, all inputs active -> all outputs 0 immediately and gnt_o=00. Release rst -> IDLE, and the next request is granted after 1 cycle.
2. m0 alone writes adr 0x10, dat 0xA5, slave acks 1 cycle after stb -> gnt_o=01 next edge; s_adr_o=0x10, s_dat_o=0xA5, s_we_o=1; m0_ack_o high exactly 1 cycle; m1_ack_o=0.
3. m0 and m1 assert cyc on the same edge out of reset -> gnt_o=01. m0 drops cyc -> gnt_o=10 on the next edge with no IDLE cycle. m1 drops cyc while both re-request simultaneously -> gnt_o=01.
4. m0 does a locked 3-beat read of 0x20..0x22 (slave returns 0x11, 0x22, 0x33) while m1 holds cyc=1 -> m0_dat_o returns 0x11, 0x22, 0x33; gnt_o stays 01 throughout; m1 is granted 1 edge after m0 drops cyc.
5. Hold cen=0 for 4 cycles while m1 requests from IDLE -> gnt_o stays 00; gnt_o=10 on the first edge with cen=1.
6. With ARB_TIMEOUT_EN, TO_CYCLES=4, m0 strobes and the slave never acks -> m0_err_o pulses on the 4th cen cycle, gnt_o goes to 00, and m0 is not re-granted until its cyc toggles. Without the macro -> gnt_o stays 01 and m0_err_o=0.
